seq_gen: RTL and testbench

SEQ_GEN -- requirements
Module: seq_gen

---
 rtl/seq_pkg.sv | 22 ++
 rtl/seq_gen.sv | 135 +++++++++++++
 tb/tb_seq_gen.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared types and default sizes for the serial pattern
//                generator and the sequence detector it feeds.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    // Default pattern length and repeat-count width
    localparam int SEQ_WIDTH = 10;
    localparam int SEQ_REP_W = 4;

    // Generator FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage : seq_pkg
`default_nettype wire

// File: rtl/seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : seq_gen
//  Description : Serialises a captured parallel pattern MSB-first, repeating
//                it back-to-back a captured number of times, then pulses done.
//                Abort cancels an active transmission without a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_gen
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WIDTH,
    parameter int REP_W = SEQ_REP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [REP_W-1:0] reps,
    input  logic             abort,
    output logic             dout,
    output logic             dout_vld,
    output logic             busy,
    output logic             done
);

    // Bit index needs at least one bit even for a 1-bit pattern
    localparam int              IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [REP_W-1:0] C_REP_ONE  = REP_W'(1);

    seq_state_t       r_state;
    logic [WIDTH-1:0] r_pat;    // captured pattern, held for reloads
    logic [IDX_W-1:0] r_idx;    // index of the bit currently on dout
    logic [REP_W-1:0] r_reps;   // repetitions still to send, incl. current
    logic             r_dout;
    logic             r_vld;
    logic             r_busy;
    logic             r_done;

    logic [IDX_W-1:0] w_next_idx;
    logic             w_last_rep;

    assign w_next_idx = r_idx - 1'b1;
    // Treat zero as "last" too so the counter can never wrap below zero
    assign w_last_rep = (r_reps == C_REP_ONE) || (r_reps == '0);

    // Control FSM with inline pattern register, bit index and repeat counter;
    // all outputs are registered so dout/dout_vld line up with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pat   <= '0;
            r_idx   <= '0;
            r_reps  <= '0;
            r_dout  <= 1'b0;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_dout <= 1'b0;
                    r_vld  <= 1'b0;
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    if (start) begin
                        r_pat  <= pattern;
                        r_reps <= reps;
                        r_idx  <= C_IDX_LAST;
                        r_busy <= 1'b1;
                        if (reps != '0) begin
                            r_state <= SEND;
                            r_dout  <= pattern[WIDTH-1];
                            r_vld   <= 1'b1;
                        end else begin
                            // Nothing to send: go straight to the done pulse
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (abort) begin
                        // Abort wins over any bit advance and skips done
                        r_state <= IDLE;
                        r_dout  <= 1'b0;
                        r_vld   <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (r_idx == '0) begin
                        if (w_last_rep) begin
                            r_state <= DONE;
                            r_reps  <= '0;
                            r_dout  <= 1'b0;
                            r_vld   <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            // Next repetition starts with no idle gap
                            r_reps <= r_reps - 1'b1;
                            r_idx  <= C_IDX_LAST;
                            r_dout <= r_pat[WIDTH-1];
                        end
                    end else begin
                        r_idx  <= w_next_idx;
                        r_dout <= r_pat[w_next_idx];
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_dout  <= 1'b0;
                    r_vld   <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_dout  <= 1'b0;
                    r_vld   <= 1'b0;
                end
            endcase
        end
    end

    assign dout     = r_dout;
    assign dout_vld = r_vld;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule : seq_gen
`default_nettype wire

// File: tb/tb_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_gen
//  Description : Scoreboard bench for seq_gen. Stimulus pushes the expected
//                serial bits and done tokens; a negedge monitor pops and
//                compares them whenever the DUT presents dout_vld or done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_gen;

    localparam int WIDTH = 10;
    localparam int REP_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [REP_W-1:0] reps;
    logic             abort;
    logic             dout;
    logic             dout_vld;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit is_done;
        bit val;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    seq_gen #(
        .WIDTH (WIDTH),
        .REP_W (REP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pattern  (pattern),
        .reps     (reps),
        .abort    (abort),
        .dout     (dout),
        .dout_vld (dout_vld),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected serial bits, MSB-first, wrapping over the pattern
    task automatic push_bits(input logic [WIDTH-1:0] p, input int count);
        exp_t e;
        for (int i = 0; i < count; i++) begin
            e.is_done = 1'b0;
            e.val     = p[WIDTH-1 - (i % WIDTH)];
            sbq.push_back(e);
        end
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.val     = 1'b0;
        sbq.push_back(e);
    endtask

    // Bounded wait for done; reports the cycle it arrived on
    task automatic wait_done(input string name, input int cur_cyc, input int exp_cyc);
        int cyc;
        cyc = cur_cyc;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
        check(name, cyc, exp_cyc);
    endtask

    // Monitor: pop and compare on every presented output
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (dout_vld || done) begin
                if (sbq.size() == 0) begin
                    check("unexpected_output", {30'd0, dout_vld, done}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    if (e.is_done) begin
                        check("done_slot", {30'd0, dout_vld, done}, 32'd1);
                    end else begin
                        check("bit_slot", {30'd0, dout_vld, done}, 32'd2);
                        check("bit_value", {31'd0, dout}, {31'd0, e.val});
                    end
                end
            end else begin
                check("dout_zero_when_invalid", {31'd0, dout}, 32'd0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = '0;
        reps    = '0;
        tick();
        tick();
        check("reset_outputs", {28'd0, dout, dout_vld, busy, done}, 32'd0);
        rst = 1'b0;
        tick();

        // Single repetition: bits on cycles 1-10, done on 11, idle on 12
        pattern = 10'b11_0110_1101;
        reps    = 4'd1;
        start   = 1'b1;
        push_bits(10'b11_0110_1101, 10);
        push_done();
        tick();
        start = 1'b0;
        check("t1_first_vld", {31'd0, dout_vld}, 32'd1);
        check("t1_first_bit", {31'd0, dout}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        wait_done("t1_done_cycle", 1, 11);
        check("t1_busy_at_done", {31'd0, busy}, 32'd1);
        tick();
        check("t1_busy_low_c12", {31'd0, busy}, 32'd0);
        check("t1_queue_empty", sbq.size(), 32'd0);

        // Three repetitions, contiguous: done on cycle 31
        reps  = 4'd3;
        start = 1'b1;
        push_bits(10'b11_0110_1101, 30);
        push_done();
        tick();
        start = 1'b0;
        wait_done("t2_done_cycle", 1, 31);
        tick();
        check("t2_busy_low", {31'd0, busy}, 32'd0);
        check("t2_queue_empty", sbq.size(), 32'd0);

        // reps=0 (abort held high, which is ignored in IDLE and DONE)
        reps  = 4'd0;
        abort = 1'b1;
        start = 1'b1;
        push_done();
        tick();
        start = 1'b0;
        check("t3_no_vld", {31'd0, dout_vld}, 32'd0);
        check("t3_done_c1", {31'd0, done}, 32'd1);
        check("t3_busy_c1", {31'd0, busy}, 32'd1);
        tick();
        abort = 1'b0;
        check("t3_idle_c2", {30'd0, busy, done}, 32'd0);
        check("t3_queue_empty", sbq.size(), 32'd0);

        // Restart attempt at cycle 5 with new pattern/reps is ignored
        pattern = 10'b11_1000_1011;
        reps    = 4'd1;
        start   = 1'b1;
        push_bits(10'b11_1000_1011, 10);
        push_done();
        tick();
        start = 1'b0;
        repeat (4) tick();
        pattern = 10'b00_0000_0001;
        reps    = 4'd2;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        pattern = '0;
        wait_done("t4_done_cycle", 6, 11);
        repeat (4) tick();
        check("t4_not_queued", {30'd0, busy, dout_vld}, 32'd0);
        check("t4_queue_empty", sbq.size(), 32'd0);

        // Abort at cycle 4, new start at cycle 7; abort during IDLE start ignored
        pattern = 10'b10_1001_1100;
        reps    = 4'd2;
        abort   = 1'b1;
        start   = 1'b1;
        push_bits(10'b10_1001_1100, 4);
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("t5_abort_idle_ignored", {31'd0, dout_vld}, 32'd1);
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_after_abort_c5", {29'd0, dout_vld, busy, done}, 32'd0);
        tick();
        tick();
        pattern = 10'b01_1100_0101;
        reps    = 4'd1;
        start   = 1'b1;
        push_bits(10'b01_1100_0101, 10);
        push_done();
        tick();
        start = 1'b0;
        check("t5_restart_vld_c8", {31'd0, dout_vld}, 32'd1);
        check("t5_restart_bit_c8", {31'd0, dout}, 32'd0);
        wait_done("t5_done_cycle", 8, 18);
        tick();
        check("t5_queue_empty", sbq.size(), 32'd0);

        // Asynchronous reset mid-cycle during SEND
        pattern = 10'b11_0110_1101;
        reps    = 4'd2;
        start   = 1'b1;
        push_bits(10'b11_0110_1101, 20);
        push_done();
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_reset_outputs", {28'd0, dout, dout_vld, busy, done}, 32'd0);
        sbq.delete();
        tick();
        tick();
        check("t6_held_reset", {28'd0, dout, dout_vld, busy, done}, 32'd0);
        rst = 1'b0;
        tick();
        pattern = 10'b01_1100_0101;
        reps    = 4'd1;
        start   = 1'b1;
        push_bits(10'b01_1100_0101, 10);
        push_done();
        tick();
        start = 1'b0;
        check("t6_post_reset_vld", {31'd0, dout_vld}, 32'd1);
        wait_done("t6_done_cycle", 1, 11);
        tick();
        check("t6_queue_empty", sbq.size(), 32'd0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_gen
`default_nettype wire
